call_dispatcher: RTL and testbench
==================================

CALL_DISPATCHER -- requirements
Module: call_dispatcher

Interface
REQ-001 Parameter NUM_FLOORS, default 7: number of floors, indexed 0..NUM_FLOORS-1.
REQ-002 Parameter DOOR_CYCLES, default 4: door-open dwell in clock cycles.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 hall_up_req, hall_dn_req  input  NUM_FLOORS each  one-cycle hall-call pulses, one bit per floor.
REQ-006 car_req_1, car_req_2  input  NUM_FLOORS each  one-cycle in-car floor-button pulses for car 1 and car 2.
REQ-007 emergency  input  2  bit1 halts car 1, bit0 halts car 2.
REQ-008 curr_floor_1, curr_floor_2  input  3 each  current floor of each car.
REQ-009 dir  input  2  bit1 car 1, bit0 car 2; 1 = up, 0 = down.
REQ-010 turn  output  2  one-cycle direction-reversal request; bit1 car 1, bit0 car 2.
REQ-011 hold_1, hold_2  output  NUM_FLOORS each  one-hot current floor while that car's door is open, else zero.
REQ-012 pending_up, pending_dn  output  NUM_FLOORS each  outstanding hall-call lamps.
REQ-013 busy  output  2  car has at least one target (bit1 car 1, bit0 car 2).

Function
REQ-014 A request pulse sets its pending bit on the next edge; pending bits stay set until serviced.
REQ-015 If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-016 Each pending hall call is assigned one cycle after it latches: to the non-halted car with the smaller |curr_floor - f|, ties to car 1. Assignment is sticky until serviced.
REQ-017 A hall call pending while both cars are halted stays unassigned; it is assigned in the first cycle after either car leaves HALT.
REQ-018 Per-car target set = that car's car calls OR its assigned hall calls.
REQ-019 Per-car FSM states: IDLE, MOVE, DOOR, HALT.
REQ-020 IDLE -> DOOR if a target equals curr_floor. IDLE -> MOVE if targets exist elsewhere. Otherwise stay in IDLE.
REQ-021 MOVE -> DOOR when curr_floor is a target. turn pulses for one cycle when no target lies ahead in dir but one lies behind.
REQ-022 turn is forced at floor 0 with dir=0 and at floor NUM_FLOORS-1 with dir=1.
REQ-023 On DOOR entry, the car call and the assigned hall call at curr_floor are cleared. hold is asserted for the DOOR cycles, then the FSM goes to MOVE if targets remain, else IDLE.
REQ-024 Any state -> HALT on the edge after the car's emergency bit rises. In HALT: hold=0, turn=0; the car's assigned hall calls are released to unassigned; car calls are kept.
REQ-025 HALT -> IDLE on the edge after the emergency bit falls.
REQ-026 emergency=2'b11: both cars in HALT; all hall calls stay pending.
REQ-027 A car whose curr_floor is >= NUM_FLOORS goes to HALT until its floor is valid again.
REQ-028 Latency: request pulse at edge n -> pending at n+1 -> assigned at n+2 -> earliest hold at n+3.

Reset
REQ-029 While resetn=0 at an edge: all pending and assignment registers are cleared, both FSMs go to IDLE, and turn, hold_1, hold_2, busy, pending_up, pending_dn are 0.
REQ-030 Reset asserted mid-DOOR or mid-HALT aborts that state on the same edge; no request survives reset.

Configuration
REQ-031 Macro DOOR_DWELL_EN. When defined, DOOR lasts DOOR_CYCLES cycles, and a new car call at curr_floor during DOOR restarts the dwell counter. When undefined, DOOR lasts exactly one cycle, there is no dwell counter, and DOOR_CYCLES is ignored.

Structure
REQ-032 Shared package elev_pkg holds the FSM state enum, the NUM_FLOORS default, and the car-index constants CAR1=1, CAR2=0.
REQ-033 Sub-module car_fsm, instantiated twice, contains the per-car FSM, the dwell counter, the turn logic and hold generation. Assignment and pending logic stay in call_dispatcher.

Verification
REQ-034 Car1 at floor 0 dir up, car2 at floor 6; hall_up_req[1] pulse -> assigned to car1, MOVE; hold_1=7'b0000010 once curr_floor_1=1; pending_up[1] clears.
REQ-035 Both cars at floor 3; hall_dn_req[3] pulse -> tie goes to car 1; hold_1=7'b0001000 at latency n+3; hold_2 stays 0.
REQ-036 Car2 at floor 6 dir up with car_req_2[2] -> turn[0] pulses exactly one cycle, then car2 services floor 2.
REQ-037 emergency=2'b01 while car2 holds an assigned hall call at floor 4 -> call moves to car 1; car 2 hold_2=0 until emergency clears, then car 2 returns to IDLE.
REQ-038 emergency=2'b11 with hall_up_req[5] pulse -> pending_up[5]=1, busy=2'b00; clearing emergency -> call assigned within one cycle.
REQ-039 Reset asserted during DOOR with DOOR_DWELL_EN defined and DOOR_CYCLES=4 -> all outputs 0 on the next edge; no hold resumes after reset releases.

Source files
------------

// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elev_pkg
// Purpose  : Shared types and constants for the two-car elevator dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package elev_pkg;

  localparam int NUM_FLOORS_DEF = 7;
  localparam int CAR1           = 1;
  localparam int CAR2           = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2,
    ST_HALT = 2'd3
  } car_state_t;

  function automatic logic [2:0] floor_dist(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_fsm.sv
`default_nettype none
// ============================================================================
// Module   : car_fsm
// Purpose  : Per-car IDLE/MOVE/DOOR/HALT controller with turn and hold outputs.
//            Optional door dwell counter enabled by macro DOOR_DWELL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module car_fsm
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  halt_req,
  input  logic [2:0]            curr_floor,
  input  logic                  dir,
  input  logic [NUM_FLOORS-1:0] targets,
  output logic                  halted,
  output logic                  service,
  output logic                  turn,
  output logic [NUM_FLOORS-1:0] hold
);

  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = NUM_FLOORS'(1);

  car_state_t state_q, state_d;
  logic       turned_q;
  logic       dir_q;
  int         cf_i;
  logic       floor_ok;
  logic       any_tgt;
  logic       tgt_here, tgt_ahead, tgt_behind;
  logic       turn_cond;

  assign cf_i     = int'(curr_floor);
  assign floor_ok = (cf_i < NUM_FLOORS);
  assign any_tgt  = |targets;

  always_comb begin
    tgt_here   = 1'b0;
    tgt_ahead  = 1'b0;
    tgt_behind = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (targets[f]) begin
        if (f == cf_i)               tgt_here   = 1'b1;
        else if ((f > cf_i) == dir)  tgt_ahead  = 1'b1;
        else                         tgt_behind = 1'b1;
      end
    end
  end

`ifdef DOOR_DWELL_EN
  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DOOR_CYCLES - 1);
  logic [CW-1:0] dwell_q;

  always_ff @(posedge clock) begin
    if (!resetn)                                     dwell_q <= '0;
    else if (service)                                dwell_q <= DWELL_LOAD;
    else if (state_q == ST_DOOR && dwell_q != '0)    dwell_q <= dwell_q - 1'b1;
  end
`else
  logic unused_door_cycles;
  assign unused_door_cycles = |DOOR_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    if (halt_req || !floor_ok) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tgt_here)     state_d = ST_DOOR;
          else if (any_tgt) state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if (tgt_here)     state_d = ST_DOOR;
          else if (!any_tgt) state_d = ST_IDLE;
        end
        ST_DOOR: begin
`ifdef DOOR_DWELL_EN
          // A fresh call at this floor keeps the door open and restarts the dwell.
          if (tgt_here || dwell_q != '0) state_d = ST_DOOR;
          else                           state_d = any_tgt ? ST_MOVE : ST_IDLE;
`else
          state_d = any_tgt ? ST_MOVE : ST_IDLE;
`endif
        end
        ST_HALT: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign service = (state_d == ST_DOOR) && ((state_q != ST_DOOR) || tgt_here);
  assign halted  = (state_q == ST_HALT);
  assign hold    = (state_q == ST_DOOR) ? (FLOOR_ONE << curr_floor) : '0;

  assign turn_cond = (tgt_behind && !tgt_ahead)
                   || (cf_i == 0 && !dir)
                   || (cf_i == NUM_FLOORS - 1 && dir);
  assign turn      = (state_q == ST_MOVE) && turn_cond && !turned_q;

  // One pulse per reversal: re-armed once dir changes or the car leaves MOVE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      turned_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      dir_q <= dir;
      if (turn)                                       turned_q <= 1'b1;
      else if (dir != dir_q || state_q != ST_MOVE)    turned_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : call_dispatcher
// Purpose  : Two-car hall/car call latching, nearest-car assignment and service.
//            Optional door dwell via macro DOOR_DWELL_EN (passed to car_fsm).
// Revision : 1.0 - initial release
// ============================================================================
module call_dispatcher
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req_1,
  input  logic [NUM_FLOORS-1:0] car_req_2,
  input  logic [1:0]            emergency,
  input  logic [2:0]            curr_floor_1,
  input  logic [2:0]            curr_floor_2,
  input  logic [1:0]            dir,
  output logic [1:0]            turn,
  output logic [NUM_FLOORS-1:0] hold_1,
  output logic [NUM_FLOORS-1:0] hold_2,
  output logic [NUM_FLOORS-1:0] pending_up,
  output logic [NUM_FLOORS-1:0] pending_dn,
  output logic [1:0]            busy
);

  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = NUM_FLOORS'(1);

  logic [NUM_FLOORS-1:0] pend_up_q, pend_dn_q;
  logic [NUM_FLOORS-1:0] call_1_q, call_2_q;
  logic [NUM_FLOORS-1:0] asg_up_1_q, asg_up_2_q, asg_dn_1_q, asg_dn_2_q;
  logic [NUM_FLOORS-1:0] pick_1, pick_2;
  logic [NUM_FLOORS-1:0] free_up, free_dn;
  logic [NUM_FLOORS-1:0] svc_mask_1, svc_mask_2;
  logic [NUM_FLOORS-1:0] clr_up, clr_dn;
  logic [NUM_FLOORS-1:0] tgt_1, tgt_2;
  logic                  halted_1, halted_2;
  logic                  service_1, service_2;
  logic                  turn_1, turn_2;

  // Nearest available car per floor; car 1 wins ties.
  generate
    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
      logic [2:0] dist_1, dist_2;
      assign dist_1    = floor_dist(curr_floor_1, 3'(f));
      assign dist_2    = floor_dist(curr_floor_2, 3'(f));
      assign pick_1[f] = !halted_1 && (halted_2 || dist_1 <= dist_2);
      assign pick_2[f] = !halted_2 && !pick_1[f];
    end
  endgenerate

  assign free_up    = pend_up_q & ~asg_up_1_q & ~asg_up_2_q;
  assign free_dn    = pend_dn_q & ~asg_dn_1_q & ~asg_dn_2_q;
  assign svc_mask_1 = service_1 ? (FLOOR_ONE << curr_floor_1) : '0;
  assign svc_mask_2 = service_2 ? (FLOOR_ONE << curr_floor_2) : '0;
  assign clr_up     = (svc_mask_1 & asg_up_1_q) | (svc_mask_2 & asg_up_2_q);
  assign clr_dn     = (svc_mask_1 & asg_dn_1_q) | (svc_mask_2 & asg_dn_2_q);
  assign tgt_1      = call_1_q | asg_up_1_q | asg_dn_1_q;
  assign tgt_2      = call_2_q | asg_up_2_q | asg_dn_2_q;

  // New request pulses are OR'd in after the clear so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_up_q  <= '0;
      pend_dn_q  <= '0;
      call_1_q   <= '0;
      call_2_q   <= '0;
      asg_up_1_q <= '0;
      asg_up_2_q <= '0;
      asg_dn_1_q <= '0;
      asg_dn_2_q <= '0;
    end else begin
      pend_up_q  <= (pend_up_q & ~clr_up) | hall_up_req;
      pend_dn_q  <= (pend_dn_q & ~clr_dn) | hall_dn_req;
      call_1_q   <= (call_1_q & ~svc_mask_1) | car_req_1;
      call_2_q   <= (call_2_q & ~svc_mask_2) | car_req_2;
      asg_up_1_q <= halted_1 ? '0 : ((asg_up_1_q & ~svc_mask_1) | (free_up & pick_1));
      asg_dn_1_q <= halted_1 ? '0 : ((asg_dn_1_q & ~svc_mask_1) | (free_dn & pick_1));
      asg_up_2_q <= halted_2 ? '0 : ((asg_up_2_q & ~svc_mask_2) | (free_up & pick_2));
      asg_dn_2_q <= halted_2 ? '0 : ((asg_dn_2_q & ~svc_mask_2) | (free_dn & pick_2));
    end
  end

  car_fsm #(
    .NUM_FLOORS (NUM_FLOORS),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_car_1 (
    .clock     (clock),
    .resetn    (resetn),
    .halt_req  (emergency[CAR1]),
    .curr_floor(curr_floor_1),
    .dir       (dir[CAR1]),
    .targets   (tgt_1),
    .halted    (halted_1),
    .service   (service_1),
    .turn      (turn_1),
    .hold      (hold_1)
  );

  car_fsm #(
    .NUM_FLOORS (NUM_FLOORS),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_car_2 (
    .clock     (clock),
    .resetn    (resetn),
    .halt_req  (emergency[CAR2]),
    .curr_floor(curr_floor_2),
    .dir       (dir[CAR2]),
    .targets   (tgt_2),
    .halted    (halted_2),
    .service   (service_2),
    .turn      (turn_2),
    .hold      (hold_2)
  );

  assign turn[CAR1] = turn_1;
  assign turn[CAR2] = turn_2;
  assign busy[CAR1] = |tgt_1;
  assign busy[CAR2] = |tgt_2;
  assign pending_up = pend_up_q;
  assign pending_dn = pend_dn_q;

endmodule
`default_nettype wire

// File: tb/tb_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_dispatcher
// Purpose  : Self-checking bench for call_dispatcher with a hold-value scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_dispatcher;

  localparam int NF          = 7;
  localparam int DOOR_CYCLES = 4;
`ifdef DOOR_DWELL_EN
  localparam int DWELL = DOOR_CYCLES;
`else
  localparam int DWELL = 1;
`endif

  logic          clock = 1'b0;
  logic          resetn;
  logic [NF-1:0] hall_up_req, hall_dn_req, car_req_1, car_req_2;
  logic [1:0]    emergency;
  logic [2:0]    curr_floor_1, curr_floor_2;
  logic [1:0]    dir;
  logic [1:0]    turn;
  logic [NF-1:0] hold_1, hold_2, pending_up, pending_dn;
  logic [1:0]    busy;

  int checks = 0;
  int errors = 0;
  logic [NF-1:0] sb[$];

  call_dispatcher #(
    .NUM_FLOORS (NF),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .hall_up_req (hall_up_req),
    .hall_dn_req (hall_dn_req),
    .car_req_1   (car_req_1),
    .car_req_2   (car_req_2),
    .emergency   (emergency),
    .curr_floor_1(curr_floor_1),
    .curr_floor_2(curr_floor_2),
    .dir         (dir),
    .turn        (turn),
    .hold_1      (hold_1),
    .hold_2      (hold_2),
    .pending_up  (pending_up),
    .pending_dn  (pending_dn),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for the chosen car's hold, then measures how long it stays up.
  task automatic observe_hold(input int car, input int budget,
                              output logic [NF-1:0] seen, output logic [NF-1:0] other,
                              output int dur);
    logic [NF-1:0] h;
    int n;
    n = 0;
    h = (car == 1) ? hold_1 : hold_2;
    while (h == '0 && n < budget) begin
      tick();
      n++;
      h = (car == 1) ? hold_1 : hold_2;
    end
    seen  = h;
    other = (car == 1) ? hold_2 : hold_1;
    dur   = 0;
    while (h != '0 && dur < 20) begin
      dur++;
      tick();
      h = (car == 1) ? hold_1 : hold_2;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (turn !== 2'b00)   begin errors++; $display("FAIL reset_turn: got %b, required 00", turn); end
    checks++; if (hold_1 !== '0)    begin errors++; $display("FAIL reset_hold_1: got %b, required 0", hold_1); end
    checks++; if (hold_2 !== '0)    begin errors++; $display("FAIL reset_hold_2: got %b, required 0", hold_2); end
    checks++; if (busy !== 2'b00)   begin errors++; $display("FAIL reset_busy: got %b, required 00", busy); end
    checks++; if (pending_up !== '0 || pending_dn !== '0) begin
      errors++; $display("FAIL reset_pending: got up %b dn %b, required 0", pending_up, pending_dn);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_assign_nearest();
    logic [NF-1:0] seen, other, exp_h;
    int dur;
    curr_floor_1 = 3'd0; curr_floor_2 = 3'd6; dir = 2'b10;
    tick();
    hall_up_req = 7'b0000010;
    sb.push_back(7'b0000010);
    tick();
    hall_up_req = '0;
    checks++; if (pending_up !== 7'b0000010) begin errors++; $display("FAIL assign_pending: got %b, required 0000010", pending_up); end
    tick();
    checks++; if (busy !== 2'b10) begin errors++; $display("FAIL assign_busy: got %b, required 10", busy); end
    tick();
    curr_floor_1 = 3'd1;
    observe_hold(1, 3, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL assign_hold_1: got %b, required %b", seen, exp_h); end
    checks++; if (other !== '0)   begin errors++; $display("FAIL assign_hold_2: got %b, required 0", other); end
    checks++; if (dur != DWELL)   begin errors++; $display("FAIL assign_dwell: got %0d, required %0d", dur, DWELL); end
    checks++; if (pending_up !== '0 || busy !== 2'b00) begin
      errors++; $display("FAIL assign_cleared: got pending %b busy %b, required 0/00", pending_up, busy);
    end
  endtask

  task automatic test_tie_latency();
    logic [NF-1:0] seen, other, exp_h;
    int dur;
    curr_floor_1 = 3'd3; curr_floor_2 = 3'd3; dir = 2'b11;
    tick();
    hall_dn_req = 7'b0001000;
    sb.push_back(7'b0001000);
    tick();
    hall_dn_req = '0;
    checks++; if (hold_1 !== '0 || pending_dn !== 7'b0001000) begin
      errors++; $display("FAIL tie_n1: got hold_1 %b pending_dn %b, required 0/0001000", hold_1, pending_dn);
    end
    tick();
    checks++; if (busy !== 2'b10 || hold_1 !== '0) begin
      errors++; $display("FAIL tie_n2: got busy %b hold_1 %b, required 10/0", busy, hold_1);
    end
    tick();
    observe_hold(1, 0, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL tie_hold_1: got %b, required %b", seen, exp_h); end
    checks++; if (other !== '0)   begin errors++; $display("FAIL tie_hold_2: got %b, required 0", other); end
    checks++; if (dur != DWELL)   begin errors++; $display("FAIL tie_dwell: got %0d, required %0d", dur, DWELL); end
  endtask

  task automatic test_turn();
    logic [NF-1:0] seen, other, exp_h;
    int dur, pulses;
    logic stray;
    curr_floor_2 = 3'd6; dir = 2'b11;
    tick();
    car_req_2 = 7'b0000100;
    sb.push_back(7'b0000100);
    tick();
    car_req_2 = '0;
    pulses = 0; stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (turn[0]) pulses++;
      if (turn[1] || hold_2 != '0) stray = 1'b1;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL turn_pulses: got %0d, required 1", pulses); end
    checks++; if (stray)       begin errors++; $display("FAIL turn_stray: got turn1/hold_2 activity, required none"); end
    dir = 2'b10;
    curr_floor_2 = 3'd2;
    observe_hold(2, 3, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL turn_hold_2: got %b, required %b", seen, exp_h); end
  endtask

  task automatic test_halt_release();
    logic [NF-1:0] seen, other, exp_h;
    int dur, n;
    logic stray;
    curr_floor_1 = 3'd0; curr_floor_2 = 3'd5; dir = 2'b10;
    tick();
    hall_up_req = 7'b0010000;
    tick();
    hall_up_req = '0;
    tick();
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL halt_first_owner: got busy %b, required 01", busy); end
    emergency = 2'b01;
    sb.push_back(7'b0010000);
    n = 0; stray = 1'b0;
    tick();
    while (busy !== 2'b10 && n < 6) begin
      if (hold_2 != '0) stray = 1'b1;
      tick();
      n++;
    end
    checks++; if (busy !== 2'b10) begin errors++; $display("FAIL halt_reassign: got busy %b, required 10", busy); end
    curr_floor_1 = 3'd4;
    observe_hold(1, 3, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL halt_hold_1: got %b, required %b", seen, exp_h); end
    checks++; if (other !== '0 || stray) begin errors++; $display("FAIL halt_hold_2: got %b, required 0", other); end
    checks++; if (pending_up !== '0) begin errors++; $display("FAIL halt_pending: got %b, required 0", pending_up); end
    emergency = 2'b00;
    tick();
    car_req_2 = 7'b0100000;
    sb.push_back(7'b0100000);
    tick();
    car_req_2 = '0;
    observe_hold(2, 2, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL halt_resume_2: got %b, required %b", seen, exp_h); end
  endtask

  task automatic test_both_halted();
    logic [NF-1:0] seen, other, exp_h;
    int dur, n;
    curr_floor_1 = 3'd4; curr_floor_2 = 3'd5;
    emergency = 2'b11;
    tick();
    tick();
    hall_up_req = 7'b0100000;
    tick();
    hall_up_req = '0;
    tick();
    tick();
    checks++; if (pending_up !== 7'b0100000 || busy !== 2'b00) begin
      errors++; $display("FAIL both_halt_hold: got pending %b busy %b, required 0100000/00", pending_up, busy);
    end
    sb.push_back(7'b0100000);
    emergency = 2'b00;
    n = 0;
    while (busy === 2'b00 && n < 4) begin
      tick();
      n++;
    end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL both_halt_assign: got busy %b, required 01", busy); end
    observe_hold(2, 3, seen, other, dur);
    exp_h = sb.pop_front();
    checks++; if (seen !== exp_h) begin errors++; $display("FAIL both_halt_hold_2: got %b, required %b", seen, exp_h); end
  endtask

  task automatic test_reset_in_door();
    logic stray;
    curr_floor_1 = 3'd2; curr_floor_2 = 3'd5; dir = 2'b11;
    tick();
    car_req_1   = 7'b0000100;
    hall_dn_req = 7'b1000000;
    tick();
    car_req_1   = '0;
    hall_dn_req = '0;
    tick();
    checks++; if (hold_1 !== 7'b0000100) begin errors++; $display("FAIL rst_door_entry: got %b, required 0000100", hold_1); end
    resetn = 1'b0;
    tick();
    checks++; if (hold_1 !== '0 || hold_2 !== '0 || turn !== 2'b00) begin
      errors++; $display("FAIL rst_door_outputs: got hold_1 %b hold_2 %b turn %b, required 0", hold_1, hold_2, turn);
    end
    checks++; if (busy !== 2'b00 || pending_dn !== '0 || pending_up !== '0) begin
      errors++; $display("FAIL rst_door_state: got busy %b up %b dn %b, required 0", busy, pending_up, pending_dn);
    end
    resetn = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hold_1 != '0 || hold_2 != '0 || busy != 2'b00) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL rst_door_resume: got activity after reset, required none"); end
  endtask

  initial begin
    resetn = 1'b0;
    hall_up_req = '0; hall_dn_req = '0; car_req_1 = '0; car_req_2 = '0;
    emergency = 2'b00; curr_floor_1 = 3'd0; curr_floor_2 = 3'd6; dir = 2'b00;
    test_reset();
    test_assign_nearest();
    test_tie_latency();
    test_turn();
    test_halt_release();
    test_both_halted();
    test_reset_in_door();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
